// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between two masters.
// Optional per-master lock (atomic RMW) enabled by defining MEM_PORT_ARB_LOCK_EN.
module mem_port_arbiter #(
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_rw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_rw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
`ifdef MEM_PORT_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          mem_en,
  output logic          read_write,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data_out,
  input  logic [DW-1:0] data_in,
  output logic          busy,
  output logic          last_grant
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pick;
  logic          m0_gnt_nxt, m0_ack_nxt, m1_gnt_nxt, m1_ack_nxt;
  logic [DW-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic          mem_en_nxt, read_write_nxt, busy_nxt, last_grant_nxt;
  logic [AW-1:0] address_nxt;
  logic [DW-1:0] data_out_nxt;
`ifdef MEM_PORT_ARB_LOCK_EN
  logic          lock_hold, lock_hold_nxt;
`endif

  // Winner of an IDLE arbitration; last_grant doubles as the in-flight owner.
  always_comb begin
    pick = m1_req & ~(m0_req & last_grant);
`ifdef MEM_PORT_ARB_LOCK_EN
    if (lock_hold && (last_grant ? m1_req : m0_req)) pick = last_grant;
`endif
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    m0_gnt_nxt     = m0_gnt;
    m1_gnt_nxt     = m1_gnt;
    m0_ack_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m0_rdata_nxt   = m0_rdata;
    m1_rdata_nxt   = m1_rdata;
    mem_en_nxt     = 1'b0;
    read_write_nxt = read_write;
    address_nxt    = address;
    data_out_nxt   = data_out;
    busy_nxt       = busy;
    last_grant_nxt = last_grant;
`ifdef MEM_PORT_ARB_LOCK_EN
    lock_hold_nxt  = lock_hold;
`endif
    case (state)
      IDLE: begin
`ifdef MEM_PORT_ARB_LOCK_EN
        // A lock survives only into the arbitration right after its ACK.
        lock_hold_nxt = 1'b0;
`endif
        if (m0_req || m1_req) begin
          state_nxt      = ISSUE;
          last_grant_nxt = pick;
          read_write_nxt = pick ? m1_rw    : m0_rw;
          address_nxt    = pick ? m1_addr  : m0_addr;
          data_out_nxt   = pick ? m1_wdata : m0_wdata;
          m0_gnt_nxt     = ~pick;
          m1_gnt_nxt     = pick;
          mem_en_nxt     = 1'b1;
          busy_nxt       = 1'b1;
        end
      end
      ISSUE: begin
        cnt_nxt   = CW'(MEM_LAT - 1);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = ACK;
          if (!read_write) begin
            if (last_grant) m1_rdata_nxt = data_in;
            else            m0_rdata_nxt = data_in;
          end
          m0_ack_nxt = ~last_grant;
          m1_ack_nxt = last_grant;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ACK: begin
        state_nxt  = IDLE;
        m0_gnt_nxt = 1'b0;
        m1_gnt_nxt = 1'b0;
        busy_nxt   = 1'b0;
`ifdef MEM_PORT_ARB_LOCK_EN
        lock_hold_nxt = last_grant ? m1_lock : m0_lock;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      mem_en     <= 1'b0;
      read_write <= 1'b0;
      address    <= '0;
      data_out   <= '0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
`ifdef MEM_PORT_ARB_LOCK_EN
      lock_hold  <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      m0_gnt     <= m0_gnt_nxt;
      m1_gnt     <= m1_gnt_nxt;
      m0_ack     <= m0_ack_nxt;
      m1_ack     <= m1_ack_nxt;
      m0_rdata   <= m0_rdata_nxt;
      m1_rdata   <= m1_rdata_nxt;
      mem_en     <= mem_en_nxt;
      read_write <= read_write_nxt;
      address    <= address_nxt;
      data_out   <= data_out_nxt;
      busy       <= busy_nxt;
      last_grant <= last_grant_nxt;
`ifdef MEM_PORT_ARB_LOCK_EN
      lock_hold  <= lock_hold_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timeline model.
// Lock scenarios compile in when MEM_PORT_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned TL    = 3;
  localparam int unsigned ACK_K = TL + 2;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          m0_req, m0_rw, m1_req, m1_rw;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, read_write, busy, last_grant;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out, data_in;
`ifdef MEM_PORT_ARB_LOCK_EN
  logic          m0_lock, m1_lock;
  bit            m_lock;
`endif

  always #5 clk_in = ~clk_in;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(TL)) dut (
    .clk_in(clk_in), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef MEM_PORT_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .mem_en(mem_en), .read_write(read_write), .address(address),
    .data_out(data_out), .data_in(data_in), .busy(busy), .last_grant(last_grant)
  );

  // Memory device: written in the enable cycle, read data valid TL cycles later.
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] ref_mem [4096];
  int            pend;
  logic [AW-1:0] rd_addr;

  initial begin
    pend = 0;
    rd_addr = '0;
    forever begin
      @(negedge clk_in);
      if (!reset && mem_en) begin
        if (read_write) mem[address] = data_out;
        else begin pend = TL; rd_addr = address; end
      end
    end
  end

  initial begin
    data_in = '0;
    forever begin
      @(posedge clk_in);
      #1;
      if (pend > 0) begin
        pend = pend - 1;
        data_in = (pend == 0) ? mem[rd_addr] : DW'($urandom);
      end else begin
        data_in = DW'($urandom);
      end
    end
  end

  // Reference model: an in-flight transaction is described by its age m_k (1 = enable cycle).
  bit            m_busy, m_own, m_last, m_rw;
  int            m_k;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rd [2];

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got %0h exp %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_last = 1; m_rw = 0; m_k = 0;
    m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
`ifdef MEM_PORT_ARB_LOCK_EN
    m_lock = 0;
`endif
    pend = 0;
  endtask

  task automatic model_step();
    bit prev_lock;
    bit pick;
    prev_lock = 0;
    if (m_busy) begin
      if (m_k == int'(ACK_K)) begin
        m_busy = 0;
`ifdef MEM_PORT_ARB_LOCK_EN
        m_lock = m_own ? m1_lock : m0_lock;
`endif
      end else begin
        m_k++;
        if (m_k == int'(ACK_K) && !m_rw) m_rd[m_own] = ref_mem[m_addr];
      end
    end else begin
`ifdef MEM_PORT_ARB_LOCK_EN
      prev_lock = m_lock;
      m_lock = 0;
`endif
      if (m0_req || m1_req) begin
        if (prev_lock && (m_last ? m1_req : m0_req)) pick = m_last;
        else if (m0_req && m1_req)                   pick = !m_last;
        else                                         pick = m1_req;
        m_busy = 1; m_k = 1; m_own = pick; m_last = pick;
        m_rw    = pick ? m1_rw : m0_rw;
        m_addr  = pick ? m1_addr : m0_addr;
        m_wdata = pick ? m1_wdata : m0_wdata;
        if (m_rw) ref_mem[m_addr] = m_wdata;
      end
    end
  endtask

  task automatic check_all();
    bit in_ack;
    in_ack = m_busy && (m_k == int'(ACK_K));
    check("m0_gnt",     64'(m0_gnt),     64'(m_busy && !m_own));
    check("m1_gnt",     64'(m1_gnt),     64'(m_busy && m_own));
    check("m0_ack",     64'(m0_ack),     64'(in_ack && !m_own));
    check("m1_ack",     64'(m1_ack),     64'(in_ack && m_own));
    check("m0_rdata",   64'(m0_rdata),   64'(m_rd[0]));
    check("m1_rdata",   64'(m1_rdata),   64'(m_rd[1]));
    check("mem_en",     64'(mem_en),     64'(m_busy && m_k == 1));
    check("read_write", 64'(read_write), 64'(m_rw));
    check("address",    64'(address),    64'(m_addr));
    check("data_out",   64'(data_out),   64'(m_wdata));
    check("busy",       64'(busy),       64'(m_busy));
    check("last_grant", 64'(last_grant), 64'(m_last));
  endtask

  // Inputs set by the caller are sampled at the coming edge; outputs checked at the next negedge.
  task automatic cycle();
    if (reset) model_reset();
    else       model_step();
    @(negedge clk_in);
    check_all();
  endtask

  task automatic rand_inputs();
    m0_req   = ($urandom_range(0, 2) != 0);
    m1_req   = ($urandom_range(0, 2) != 0);
    m0_rw    = 1'($urandom);
    m1_rw    = 1'($urandom);
    m0_addr  = AW'($urandom_range(0, 15));
    m1_addr  = AW'($urandom_range(0, 15));
    m0_wdata = DW'($urandom);
    m1_wdata = DW'($urandom);
`ifdef MEM_PORT_ARB_LOCK_EN
    m0_lock  = 1'($urandom);
    m1_lock  = 1'($urandom);
`endif
  endtask

  int q[$];

  task automatic log_acks();
    if (m0_ack) q.push_back(0);
    if (m1_ack) q.push_back(1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    mem[12'h005] = 32'hDEADBEEF;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    phase = "reset";
    reset = 1'b1;
    rand_inputs();
    repeat (4) begin rand_inputs(); cycle(); end

    phase = "idle";
    reset = 1'b0;
    m0_req = 0; m1_req = 0;
    repeat (3) cycle();

    phase = "m0_read";
    m0_req = 1; m0_rw = 0; m0_addr = 12'h005;
    cycle();
    check("rd_addr", 64'(address), 64'h005);
    m0_req = 0; m0_addr = 12'h3FF; m0_rw = 1;
    repeat (ACK_K) cycle();
    check("rd_data", 64'(m0_rdata), 64'hDEADBEEF);

    phase = "m1_write";
    m1_req = 1; m1_rw = 1; m1_addr = 12'h0A0; m1_wdata = 32'h12345678;
    cycle();
    check("wr_dout", 64'(data_out), 64'h12345678);
    m1_req = 0; m1_wdata = 32'h0;
    repeat (ACK_K) cycle();
    check("wr_mem", 64'(mem[12'h0A0]), 64'h12345678);
    check("wr_rdata", 64'(m1_rdata), 64'h0);

    phase = "rr";
    q.delete();
    m0_req = 1; m1_req = 1; m0_rw = 0; m1_rw = 0;
    for (int i = 0; i < 4 * int'(TL + 3); i++) begin cycle(); log_acks(); end
    m0_req = 0; m1_req = 0;
    cycle();
    check("rr_count", 64'(q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("rr_order", 64'((i < q.size()) ? q[i] : -1), 64'(i % 2));

    phase = "rst_wait";
    m1_req = 1; m1_rw = 0; m1_addr = 12'h007;
    cycle();
    m1_req = 0;
    cycle(); cycle();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle(); cycle();
    reset = 1'b0;
    m0_req = 1; m1_req = 1;
    cycle();
    check("tie_m0", 64'(m0_gnt), 64'd1);
    m0_req = 0; m1_req = 0;
    repeat (ACK_K + 1) cycle();

`ifdef MEM_PORT_ARB_LOCK_EN
    phase = "lock";
    q.delete();
    m0_lock = 1; m1_lock = 0; m0_req = 1; m1_req = 0;
    for (int i = 0; i < 4 * int'(TL + 3); i++) begin
      if (i == 1) m1_req = 1;
      if (i == 2 * int'(TL + 3)) m0_lock = 0;
      cycle(); log_acks();
    end
    m0_req = 0; m1_req = 0;
    cycle();
    check("lock_count", 64'(q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("lock_order", 64'((i < q.size()) ? q[i] : -1), 64'(i == 3));
`endif

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 12-bit-address / 32-bit-data memory port between two requesters, e.g. the cpu core (master 0) and a program loader / debug port (master 1).
- Round-robin arbitration; one transaction in flight at a time.
- Fixed-latency memory timing is sequenced by an internal FSM.
- Drives the memory-side mem_en / read_write / address / data_out signals and returns read data with a one-cycle ack per master.

Parameters:
AW, 12, address width
DW, 32, data width
MEM_LAT, 1, cycles from the mem_en cycle until data_in is valid; legal 1..15

Ports:
clk_in  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
m0_req  in  1  master 0 transaction request, level
m0_rw  in  1  0 = read, 1 = write
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_gnt  out  1  master 0 owns the port, ISSUE through ACK
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DW  read data, valid from ack cycle, held until next m0 read completes
m1_req, m1_rw, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata  same as master 0, for master 1
mem_en  out  1  memory enable
read_write  out  1  0 = read, 1 = write
address  out  AW  memory address
data_out  out  DW  memory write data
data_in  in  DW  memory read data
busy  out  1  high whenever state != IDLE
last_grant  out  1  index of the most recently granted master

Behaviour:
- Reset values: all outputs 0, except last_grant = 1 so master 0 wins the first tie. State = IDLE, latency counter = 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: requests are sampled on each edge.
  - Only one req high: that master is granted.
  - Both high: the master != last_grant is granted.
  - On grant: latch rw/addr/wdata into read_write/address/data_out, update last_grant, set that master's gnt, go to ISSUE.
  - No req: stay in IDLE.
- ISSUE: exactly one cycle. mem_en = 1, counter loaded with MEM_LAT - 1, next state WAIT.
- WAIT: MEM_LAT cycles, mem_en = 0.
  - Counter decrements each cycle.
  - On the edge where counter == 0, a read captures data_in into the granted master's rdata; next state ACK.
- ACK: exactly one cycle. Granted master's ack = 1, gnt still high. Next state IDLE, gnt cleared.
- Timing: a request sampled in cycle C0 gives mem_en in C1 and ack in C(2+MEM_LAT).
  - Minimum turnaround is 3 + MEM_LAT cycles per transaction, since IDLE is always visited for one cycle.
- Hold: address / read_write / data_out stay stable from ISSUE until the next grant; they are not cleared in IDLE.
- Write completion: ack pulses; rdata is unchanged.
- Requester rule: req still high in the IDLE cycle after ack is a new transaction. A requester wanting a single access drops req in its ack cycle.
- req or inputs changing after grant: ignored; the in-flight transaction completes with the latched values and ack is still pulsed.
- Non-granted master: its ack/gnt are never asserted.
- Reset during ISSUE/WAIT/ACK: transaction is abandoned, no ack, mem_en drops immediately, all reset values apply.

Optional Feature:
Macro: MEM_PORT_ARB_LOCK_EN.
- Defined:
  - Adds input ports m0_lock and m1_lock (1 bit each).
  - If the granted master's lock is high during its ACK cycle, that master has absolute priority at the next IDLE arbitration when it requests, overriding round-robin; last_grant still updates.
  - Lock is released when the holder's lock is low at ACK, or the holder does not request in IDLE; normal round-robin then resumes.
  - Intended for atomic read-modify-write.
- Undefined: no lock ports; pure round-robin as above.

Test Plan:
- Reset with random inputs -> all outputs 0, last_grant = 1, busy = 0; outputs stay 0 until a req.
- MEM_LAT = 1, memory[0x005] = 0xDEADBEEF, m0 read 0x005 with req pulsed at C0 -> mem_en = 1 only in C1, address 0x005, read_write 0; m0_ack in C3; m0_rdata = 0xDEADBEEF; m1 signals stay 0.
- m1 write addr 0x0A0, data 0x12345678 -> C1: mem_en = 1, read_write = 1, data_out = 0x12345678; memory[0x0A0] updated; m1_ack in C3; m1_rdata unchanged.
- Both req held high for 4 transactions -> grant order m0, m1, m0, m1; each ack 4 cycles apart from the previous; busy low for exactly one cycle between transactions.
- MEM_LAT = 3, reset asserted in the second WAIT cycle of an m1 read -> mem_en/gnt/ack low immediately, no m1_ack; after release a tie grants m0.
- With MEM_PORT_ARB_LOCK_EN, both req high, m0_lock = 1 for 3 transactions -> m0 granted 3 times consecutively; m0_lock dropped -> next grant m1.
